onchip_sram_dp_clr: RTL
=======================

// Module: onchip_sram_dp_clr
// PURPOSE
//  Parametrised true-dual-port on-chip SRAM with two Avalon-MM slaves (s1, s2) for pixel/char buffers.
//  Adds byte enables, optional output register, and a readdatavalid pipeline.
//  Adds a hardware clear engine that zeroes the array after reset or on request, stalling both slaves via waitrequest.
//  Sits between the HPS/video bridges and the VGA pixel reader.
// PARAMETERS
//  DATA_W      8   data width per word; multiple of 8 (8..64)
//  ADDR_W      17  word address width; DEPTH = 2**ADDR_W
//  OUT_REG     0   1 = registered q, adds one cycle of read latency
//  INIT_CLEAR  1   1 = run clear after reset; 0 = array contents undefined, no clear after reset
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous active-high reset
//  clear_req    in   1         pulse: re-zero array (ignored unless READY)
//  clear_busy   out  1         high while clear engine runs
//  address      in   ADDR_W    s1 word address
//  chipselect   in   1         s1 select
//  clken        in   1         s1 clock enable; 0 stalls s1
//  read         in   1         s1 read
//  write        in   1         s1 write
//  byteenable   in   DATA_W/8  s1 byte lanes
//  writedata    in   DATA_W    s1 write data
//  readdata     out  DATA_W    s1 read data
//  readdatavalid out 1         s1 read data valid
//  waitrequest  out  1         s1 stall
//  address2, chipselect2, clken2, read2, write2, byteenable2, writedata2,
//  readdata2, readdatavalid2, waitrequest2: s2 equivalents, same widths
// BEHAVIOUR
//  Reset values (async):
//   - readdata/readdata2 = 0; readdatavalid* = 0.
//   - waitrequest* = clear_busy = INIT_CLEAR.
//   - FSM = CLEAR if INIT_CLEAR, else READY; clear address counter = 0.
//  FSM states CLEAR and READY:
//   - CLEAR writes 0 to all byte lanes at clr_addr via port A, one word per clk.
//   - CLEAR -> READY after writing DEPTH-1, so the sweep lasts DEPTH cycles.
//   - READY -> CLEAR on clear_req; clr_addr is reset to 0.
//   - Reset asserted mid-clear: counter returns to 0 and the full sweep restarts.
//  Slave acceptance:
//   - waitrequest* = clear_busy.
//   - Access accepted when chipselect & clken & ~waitrequest.
//   - Accepted cycles during CLEAR: none; the master holds its request.
//   - Write: byte lane i updated iff byteenable[i].
//   - Read & write high in the same cycle: write only, no readdatavalid.
//  Read latency:
//   - Accepted read at edge N gives readdata valid and readdatavalid=1 after edge N+1+OUT_REG.
//   - Exactly one readdatavalid pulse per accepted read; reads fully pipelined, one per cycle.
//   - Reads issued just before clear_req still complete.
//   - readdata holds its last value when readdatavalid=0.
//  clken*=0:
//   - The port's pipeline stages hold their contents.
//   - readdatavalid* is forced to 0 while stalled.
//   - A held valid is emitted on the first cycle with clken*=1.
//  Collisions:
//   - Both ports write the same address in the same cycle: s1 data wins on overlapping enabled lanes; other lanes merge.
//   - Same-port read-during-write: not possible (write priority).
//   - Mixed-port read-during-write, same address: returns OLD data.
// STRUCTURE
//  Package onchip_sram_pkg:
//   - FSM state enum {CLEAR, READY}.
//   - Latency constant RD_LAT = 1+OUT_REG.
//  Sub-module onchip_sram_dp_core:
//   - Inferred true-dual-port byte-enabled array.
//   - Old-data mixed-port mode; optional q register.
//   - Implements the s1 collision priority.
//  Top level: clear FSM/counter, port-A mux (clear vs s1), accept logic, valid pipelines.
// TESTING
//  - Reset release, ADDR_W=4, INIT_CLEAR=1 -> waitrequest high exactly 16 cycles, then all 16 reads return 0.
//  - s1 write 0xA5 @0x10, then read @0x10 -> readdatavalid one cycle after accept (OUT_REG=0), two cycles after (OUT_REG=1); readdata=0xA5.
//  - DATA_W=32, write 0x11223344, then byteenable=0b0101 data 0xAABBCCDD -> read 0x11BB33DD.
//  - Same cycle, addr 3: s1 writes 0x01, s2 writes 0x02 -> readback 0x01.
//  - Same cycle: s2 reads addr 5 (holding 0x77) while s1 writes 0x99 -> s2 gets 0x77, next read gets 0x99.
//  - clear_req mid-operation with 2 reads in flight, clken pulsed low for 3 cycles -> both valids delivered once; array zero after DEPTH cycles.
//  - Reset pulsed during clear -> sweep restarts at address 0.

Source files
------------

// File: rtl/onchip_sram_pkg.sv
// rtl/onchip_sram_pkg.sv - shared types and constants for the dual-port clearable SRAM
// Contents:
//   clr_state_e : clear engine state (CLEAR sweeping the array, READY serving slaves)
//   rd_lat()    : read latency in cycles for a given output-register setting
package onchip_sram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_e;

   // RD_LAT = 1 + OUT_REG: one cycle for the array read, one more for the q register
   function automatic int rd_lat(input int out_reg);
      return 1 + out_reg;
   endfunction

endpackage

// File: rtl/onchip_sram_dp_clr_if.sv
// rtl/onchip_sram_dp_clr_if.sv - Avalon-MM slave bundle for one SRAM port
// Signals:
//   address, chipselect, clken, read, write, byteenable, writedata : master -> slave
//   readdata, readdatavalid, waitrequest                           : slave -> master
// Modports: master (bus master side), slave (SRAM side)
interface onchip_sram_dp_clr_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0]   address;
   logic                chipselect;
   logic                clken;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, chipselect, clken, read, write, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, chipselect, clken, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/onchip_sram_dp_core.sv
// rtl/onchip_sram_dp_core.sv - true-dual-port byte-enabled RAM array with optional q register
// Ports:
//   clk, reset          : clock, async active-high reset (q registers only)
//   a_we/b_we           : write strobe, a_be/b_be byte lanes, a_wdata/b_wdata data
//   a_rd/b_rd           : load the read register from a_addr/b_addr
//   a_qen/b_qen         : load the optional output register (OUT_REG=1 only)
//   a_q/b_q             : read data
// Mixed-port read-during-write returns the old word; on a same-address double
// write port A (s1) wins on overlapping lanes.
module onchip_sram_dp_core #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 17,
   parameter int OUT_REG = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                a_we,
   input  logic                a_rd,
   input  logic                a_qen,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_wdata,
   output logic [DATA_W-1:0]   a_q,
   input  logic                b_we,
   input  logic                b_rd,
   input  logic                b_qen,
   input  logic [DATA_W/8-1:0] b_be,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_wdata,
   output logic [DATA_W-1:0]   b_q
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] a_r, b_r;

   // Port B lanes are scheduled first so port A's assignment lands last on collisions
   always_ff @(posedge clk) begin
      for (int i = 0; i < DATA_W/8; i++) begin
         if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
         if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
   end

   // Reads sample the array before this edge's writes land: old-data behaviour
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r <= '0;
         b_r <= '0;
      end else begin
         if (a_rd) a_r <= mem[a_addr];
         if (b_rd) b_r <= mem[b_addr];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] a_qr, b_qr;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_qr <= '0;
               b_qr <= '0;
            end else begin
               if (a_qen) a_qr <= a_r;
               if (b_qen) b_qr <= b_r;
            end
         end
         assign a_q = a_qr;
         assign b_q = b_qr;
      end else begin : g_noreg
         logic unused_qen;
         assign unused_qen = a_qen ^ b_qen;
         assign a_q = a_r;
         assign b_q = b_r;
      end
   endgenerate
endmodule

// File: rtl/onchip_sram_dp_clr.sv
// rtl/onchip_sram_dp_clr.sv - dual-port on-chip SRAM with hardware clear engine
// Ports:
//   clk, reset  : clock, async active-high reset
//   clear_req   : pulse to re-zero the array (taken only when READY)
//   clear_busy  : high while the clear sweep runs; also drives both waitrequests
//   s1, s2      : Avalon-MM slave ports (onchip_sram_dp_clr_if.slave)
// The clear sweep borrows port A from s1, writing one zero word per cycle.
module onchip_sram_dp_clr
   import onchip_sram_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 17,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_req,
   output logic               clear_busy,
   onchip_sram_dp_clr_if.slave s1,
   onchip_sram_dp_clr_if.slave s2
);
   localparam int RD_LAT = rd_lat(OUT_REG);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= (INIT_CLEAR != 0) ? CLEAR : READY;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (&clr_addr_q) state_d = READY;
         end
         READY: begin
            if (clear_req) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         default: state_d = READY;
      endcase
   end

   assign clear_busy     = (state_q == CLEAR);
   assign s1.waitrequest = clear_busy;
   assign s2.waitrequest = clear_busy;

   // A simultaneous read+write is treated as a write only
   logic acc1, wr1, rd1, acc2, wr2, rd2;
   assign acc1 = s1.chipselect & s1.clken & ~clear_busy;
   assign wr1  = acc1 & s1.write;
   assign rd1  = acc1 & s1.read & ~s1.write;
   assign acc2 = s2.chipselect & s2.clken & ~clear_busy;
   assign wr2  = acc2 & s2.write;
   assign rd2  = acc2 & s2.read & ~s2.write;

   logic                a_we;
   logic [DATA_W/8-1:0] a_be;
   logic [ADDR_W-1:0]   a_addr;
   logic [DATA_W-1:0]   a_wdata;
   assign a_we    = clear_busy | wr1;
   assign a_be    = clear_busy ? '1 : s1.byteenable;
   assign a_addr  = clear_busy ? clr_addr_q : s1.address;
   assign a_wdata = clear_busy ? '0 : s1.writedata;

   // Valid shift registers advance only while their port's clken is high, so a
   // stalled pipeline keeps its reads and releases them once clken returns.
   logic [RD_LAT-1:0] vld1_q, vld2_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld1_q <= '0;
         vld2_q <= '0;
      end else begin
         if (s1.clken) vld1_q <= RD_LAT'({vld1_q, rd1});
         if (s2.clken) vld2_q <= RD_LAT'({vld2_q, rd2});
      end
   end

   assign s1.readdatavalid = vld1_q[RD_LAT-1] & s1.clken;
   assign s2.readdatavalid = vld2_q[RD_LAT-1] & s2.clken;

   onchip_sram_dp_core #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .OUT_REG (OUT_REG)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .a_we    (a_we),
      .a_rd    (rd1),
      .a_qen   (s1.clken & vld1_q[0]),
      .a_be    (a_be),
      .a_addr  (a_addr),
      .a_wdata (a_wdata),
      .a_q     (s1.readdata),
      .b_we    (wr2),
      .b_rd    (rd2),
      .b_qen   (s2.clken & vld2_q[0]),
      .b_be    (s2.byteenable),
      .b_addr  (s2.address),
      .b_wdata (s2.writedata),
      .b_q     (s2.readdata)
   );
endmodule
